// File: rtl/stack_ctrl_if.sv
// Request/status bundle between a call/return sequencer and stack_ctrl,
// plus the strobes stack_ctrl issues to the register-file stack.
interface stack_ctrl_if;
  logic       sc_call;
  logic       sc_ret;
  logic       sc_clr;
  logic       sc_ready;
  logic       sc_empty;
  logic       sc_full;
  logic       sc_overflow;
  logic       sc_underflow;
  logic       sc_conflict;
  logic       rf_stack_push;
  logic       rf_stack_pop;
  logic [5:0] rf_stack_pointer;

  modport master (
    output sc_call, sc_ret, sc_clr,
    input  sc_ready, sc_empty, sc_full, sc_overflow, sc_underflow, sc_conflict,
    input  rf_stack_push, rf_stack_pop, rf_stack_pointer
  );

  modport slave (
    input  sc_call, sc_ret, sc_clr,
    output sc_ready, sc_empty, sc_full, sc_overflow, sc_underflow, sc_conflict,
    output rf_stack_push, rf_stack_pop, rf_stack_pointer
  );
endinterface

// File: rtl/stack_ctrl.sv
// Call/return frame-pointer controller: one push or pop per accepted request,
// a programmable settle gap afterwards, and sticky error flags for bad requests.
module stack_ctrl #(
  parameter int DEPTH  = 8,
  parameter int SETTLE = 1
) (
  input logic         clk,
  input logic         rst,
  stack_ctrl_if.slave sc
);
  typedef enum logic [1:0] {IDLE, PUSH, POP, HOLD} state_e;

  localparam logic [5:0] DEPTH_P   = 6'(DEPTH);
  localparam logic [2:0] HOLD_INIT = (SETTLE > 0) ? 3'(SETTLE - 1) : 3'd0;
  localparam state_e     AFTER_OP  = (SETTLE == 0) ? IDLE : HOLD;

  state_e     state_q;
  logic [5:0] sp_q, ptr_q;
  logic [2:0] cnt_q;
  logic       ready_q, push_q, pop_q;
  logic       ovf_q, unf_q, cnf_q;
  logic       ovf_d, unf_d, cnf_d;
  logic       idle, call_only, ret_only, do_push, do_pop;

  assign idle      = (state_q == IDLE);
  assign call_only = sc.sc_call & ~sc.sc_ret;
  assign ret_only  = sc.sc_ret & ~sc.sc_call;
  assign do_push   = idle & call_only & (sp_q != DEPTH_P);
  assign do_pop    = idle & ret_only & (sp_q != 6'd0);

  // A flag raised in the same cycle as a clear stays set.
  assign ovf_d = (idle & call_only & (sp_q == DEPTH_P)) | (ovf_q & ~sc.sc_clr);
  assign unf_d = (idle & ret_only & (sp_q == 6'd0))     | (unf_q & ~sc.sc_clr);
  assign cnf_d = (idle & sc.sc_call & sc.sc_ret)        | (cnf_q & ~sc.sc_clr);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sp_q    <= 6'd0;
      ptr_q   <= 6'd0;
      cnt_q   <= 3'd0;
      ready_q <= 1'b1;
      push_q  <= 1'b0;
      pop_q   <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      cnf_q   <= 1'b0;
    end else begin
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
      cnf_q  <= cnf_d;
      push_q <= 1'b0;
      pop_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (do_push) begin
            state_q <= PUSH;
            push_q  <= 1'b1;
            ptr_q   <= sp_q + 6'd1;
            ready_q <= 1'b0;
          end else if (do_pop) begin
            state_q <= POP;
            pop_q   <= 1'b1;
            ready_q <= 1'b0;
          end
        end
        PUSH: begin
          // ptr_q already holds sp+1, which is the new sp
          sp_q    <= sp_q + 6'd1;
          state_q <= AFTER_OP;
          cnt_q   <= HOLD_INIT;
          ready_q <= (SETTLE == 0);
        end
        POP: begin
          sp_q    <= sp_q - 6'd1;
          ptr_q   <= sp_q - 6'd1;
          state_q <= AFTER_OP;
          cnt_q   <= HOLD_INIT;
          ready_q <= (SETTLE == 0);
        end
        HOLD: begin
          if (cnt_q == 3'd0) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign sc.sc_ready         = ready_q;
  assign sc.sc_empty         = (sp_q == 6'd0);
  assign sc.sc_full          = (sp_q == DEPTH_P);
  assign sc.sc_overflow      = ovf_q;
  assign sc.sc_underflow     = unf_q;
  assign sc.sc_conflict      = cnf_q;
  assign sc.rf_stack_push    = push_q;
  assign sc.rf_stack_pop     = pop_q;
  assign sc.rf_stack_pointer = ptr_q;
endmodule

// File: tb/tb_stack_ctrl.sv
// Vector table plus hand-written reset sequences for stack_ctrl (DEPTH=8, SETTLE=1).
module tb_stack_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;

  stack_ctrl_if bus ();

  stack_ctrl #(.DEPTH(8), .SETTLE(1)) dut (.clk(clk), .rst(rst), .sc(bus));

  always #5 clk = ~clk;

  // flg bit order: {ready, empty, full, overflow, underflow, conflict, push, pop}
  typedef struct packed {
    logic       rst;
    logic       call;
    logic       ret;
    logic       clr;
    logic [7:0] flg;
    logic [5:0] ptr;
  } vec_t;

  typedef struct {
    logic [7:0] flg;
    logic [5:0] ptr;
    int         tag;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic add(input logic r, c, t, k, input logic [7:0] f, input logic [5:0] p);
    vec_t v;
    v = '{rst: r, call: c, ret: t, clr: k, flg: f, ptr: p};
    tbl.push_back(v);
  endtask

  task automatic cyc(input logic r, c, t, k, input logic [7:0] f, input logic [5:0] p,
                     input int tag);
    exp_t       e;
    logic [7:0] af;
    rst = r;
    bus.sc_call = c;
    bus.sc_ret  = t;
    bus.sc_clr  = k;
    sb.push_back('{flg: f, ptr: p, tag: tag});
    @(posedge clk);
    @(negedge clk);
    e  = sb.pop_front();
    af = {bus.sc_ready, bus.sc_empty, bus.sc_full, bus.sc_overflow,
          bus.sc_underflow, bus.sc_conflict, bus.rf_stack_push, bus.rf_stack_pop};
    checks++;
    if (af !== e.flg || bus.rf_stack_pointer !== e.ptr) begin
      errors++;
      $display("FAIL step%0d: got flags=%b ptr=%0d, expected flags=%b ptr=%0d",
               e.tag, af, bus.rf_stack_pointer, e.flg, e.ptr);
    end
  endtask

  initial begin
    bus.sc_call = 1'b0;
    bus.sc_ret  = 1'b0;
    bus.sc_clr  = 1'b0;

    // single push then pop
    add(0,1,0,0, 8'b0100_0010, 6'd1);
    add(0,0,0,0, 8'b0000_0000, 6'd1);
    add(0,0,0,0, 8'b1000_0000, 6'd1);
    add(0,0,1,0, 8'b0000_0001, 6'd1);
    add(0,0,0,0, 8'b0100_0000, 6'd0);
    add(0,0,0,0, 8'b1100_0000, 6'd0);
    // underflow, conflict, clear, set-beats-clear
    add(0,0,1,0, 8'b1100_1000, 6'd0);
    add(0,1,1,0, 8'b1100_1100, 6'd0);
    add(0,0,0,1, 8'b1100_0000, 6'd0);
    add(0,0,1,1, 8'b1100_1000, 6'd0);
    add(0,0,0,1, 8'b1100_0000, 6'd0);
    // requests outside IDLE are dropped
    add(0,1,0,0, 8'b0100_0010, 6'd1);
    add(0,0,1,0, 8'b0000_0000, 6'd1);
    add(0,1,0,0, 8'b1000_0000, 6'd1);
    // sc_call held high: one push every 3 cycles up to full
    for (int s = 1; s < 8; s++) begin
      add(0,1,0,0, 8'b0000_0010,             6'(s + 1));
      add(0,1,0,0, {2'b00, s == 7, 5'b00000}, 6'(s + 1));
      add(0,1,0,0, {2'b10, s == 7, 5'b00000}, 6'(s + 1));
    end
    // overflow at full, sticky, cleared, then pop from the top
    add(0,1,0,0, 8'b1011_0000, 6'd8);
    add(0,0,0,0, 8'b1011_0000, 6'd8);
    add(0,0,0,1, 8'b1010_0000, 6'd8);
    add(0,0,1,0, 8'b0010_0001, 6'd8);
    add(0,0,0,0, 8'b0000_0000, 6'd7);
    add(0,0,0,0, 8'b1000_0000, 6'd7);
    add(0,1,1,0, 8'b1000_0100, 6'd7);
    add(0,0,0,1, 8'b1000_0000, 6'd7);

    repeat (2) @(negedge clk);
    cyc(1,0,0,0, 8'b1100_0000, 6'd0, 900);
    cyc(0,0,0,0, 8'b1100_0000, 6'd0, 901);

    foreach (tbl[i])
      cyc(tbl[i].rst, tbl[i].call, tbl[i].ret, tbl[i].clr, tbl[i].flg, tbl[i].ptr, i);

    // reset during the HOLD after a push from sp=2
    cyc(1,0,0,0, 8'b1100_0000, 6'd0, 1000);
    cyc(0,1,0,0, 8'b0100_0010, 6'd1, 1001);
    cyc(0,0,0,0, 8'b0000_0000, 6'd1, 1002);
    cyc(0,0,0,0, 8'b1000_0000, 6'd1, 1003);
    cyc(0,1,0,0, 8'b0000_0010, 6'd2, 1004);
    cyc(0,0,0,0, 8'b0000_0000, 6'd2, 1005);
    cyc(0,0,0,0, 8'b1000_0000, 6'd2, 1006);
    cyc(0,1,0,0, 8'b0000_0010, 6'd3, 1007);
    cyc(0,0,0,0, 8'b0000_0000, 6'd3, 1008);
    cyc(1,0,0,0, 8'b1100_0000, 6'd0, 1009);
    cyc(0,0,0,0, 8'b1100_0000, 6'd0, 1010);
    // reset while the push strobe is out
    cyc(0,1,0,0, 8'b0100_0010, 6'd1, 1011);
    cyc(1,0,0,0, 8'b1100_0000, 6'd0, 1012);
    cyc(0,0,0,0, 8'b1100_0000, 6'd0, 1013);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/stack_ctrl.md
STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 Parameter DEPTH, default 8, maximum stack frames (1..63); SHALL fit the 6-bit pointer.
REQ-002 Parameter SETTLE, default 1, idle cycles after each push/pop before the next request is accepted (0..7).
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 sc_call  in  1  request push of one frame.
REQ-006 sc_ret  in  1  request pop of one frame.
REQ-007 sc_clr  in  1  clear sticky error flags.
REQ-008 sc_ready  out  1  high when a request will be accepted this cycle.
REQ-009 sc_empty / sc_full  out  1 each  sp==0 / sp==DEPTH.
REQ-010 sc_overflow / sc_underflow / sc_conflict  out  1 each  sticky error flags.
REQ-011 rf_stack_push / rf_stack_pop  out  1 each  one-cycle strobes to the register file stack interface.
REQ-012 rf_stack_pointer  out  6  frame index presented to the register file.

Function
REQ-013 Internal pointer sp SHALL be 6 bits, range 0..DEPTH, never wrap.
REQ-014 FSM states: IDLE, PUSH, POP, HOLD.
REQ-015 sc_ready SHALL be 1 only in IDLE; requests outside IDLE SHALL be ignored (not queued).
REQ-016 IDLE, sc_call=1, sc_ret=0, sp<DEPTH -> PUSH next cycle.
REQ-017 IDLE, sc_ret=1, sc_call=0, sp>0 -> POP next cycle.
REQ-018 PUSH: rf_stack_push=1 and rf_stack_pointer=sp+1 for exactly one cycle; sp<=sp+1 at the end of that cycle.
REQ-019 POP: rf_stack_pop=1 and rf_stack_pointer=sp for exactly one cycle; sp<=sp-1 at the end of that cycle.
REQ-020 After PUSH/POP: HOLD for SETTLE cycles, then IDLE; with SETTLE=0, go directly to IDLE.
REQ-021 Outside PUSH, rf_stack_pointer SHALL equal sp; push/pop strobes SHALL never be high together.
REQ-022 IDLE, sc_call=1, sp==DEPTH -> no strobe, sp unchanged, sc_overflow<=1, stay IDLE.
REQ-023 IDLE, sc_ret=1, sp==0 -> no strobe, sp unchanged, sc_underflow<=1, stay IDLE.
REQ-024 IDLE, sc_call=1 and sc_ret=1 -> neither executed, sc_conflict<=1, stay IDLE.
REQ-025 Error flags SHALL hold until sc_clr=1; they clear the next cycle. An error set in the same cycle as sc_clr wins (the flag ends the cycle set).
REQ-026 Errors SHALL NOT block later valid requests.
REQ-027 Latency: request accepted at edge N -> strobe during cycle N+1; sc_ready high again at cycle N+2+SETTLE.
REQ-028 sc_empty/sc_full SHALL be combinational from sp.

Reset
REQ-029 rst=1 at a clock edge -> sp=0, state IDLE, all strobes and error flags 0, rf_stack_pointer=0.
REQ-030 sc_ready SHALL be 1 in the first cycle after rst is released.
REQ-031 rst during PUSH/POP/HOLD SHALL abort: no further strobe issues, and sp returns to 0 regardless of the pending update.

Verification
REQ-032 After reset, pulse sc_call once -> one cycle with rf_stack_push=1 and rf_stack_pointer=1; afterwards sp=1, sc_empty=0.
REQ-033 From sp=1, pulse sc_ret -> one cycle with rf_stack_pop=1 and rf_stack_pointer=1; then rf_stack_pointer=0 and sc_empty=1.
REQ-034 Perform 8 pushes (DEPTH=8), then a 9th sc_call -> no strobe, sc_full=1, sc_overflow=1; sc_clr -> sc_overflow=0.
REQ-035 sc_ret at sp=0 -> sc_underflow=1 and no strobe; sc_call with sc_ret together -> sc_conflict=1 and sp unchanged.
REQ-036 Hold sc_call high continuously with SETTLE=1 -> one push every 3 cycles; sc_ready=0 between pushes.
REQ-037 Assert rst during the HOLD that follows a push from sp=2 -> sp=0 next cycle, no strobes, sc_ready=1.
